// File: rtl/cnt_pkg.sv
// Shared constants for the modulo-N free-running counter.
// CNT_W is the reference counter width; CNT_ZERO is the reset/wrap value.
package cnt_pkg;

   localparam int CNT_W = 8;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CNT_ZERO = '0;

endpackage : cnt_pkg

// File: rtl/mod_n_tc.sv
// Terminal-count compare for a modulo-N counter: tc = (cnt >= N-1).
// A modulus input of 0 selects N = 2**WIDTH (full-range free run).
module mod_n_tc
   import cnt_pkg::*;
#(
   parameter int WIDTH = CNT_W
) (
   input  logic [WIDTH-1:0] cnt,
   input  logic [WIDTH-1:0] n_mod,
   output logic             tc
);

   logic [WIDTH:0] n_eff;
   logic [WIDTH:0] cnt_plus_one;

   // One extra bit holds N = 2**WIDTH, and comparing cnt+1 >= N avoids the N-1 underflow.
   always_comb begin
      n_eff = {1'b0, n_mod};
      if (n_mod == '0) begin
         n_eff = {1'b1, {WIDTH{1'b0}}};
      end
      cnt_plus_one = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
      tc           = (cnt_plus_one >= n_eff);
   end

endmodule : mod_n_tc

// File: rtl/bin_256_cnt_free_run.sv
// Free-running modulo-N up counter with asynchronous active-low reset.
// n_conut is used live each edge; q comes straight from the count register.
module bin_256_cnt_free_run
   import cnt_pkg::*;
#(
   parameter int WIDTH = CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] n_conut,
   output logic [WIDTH-1:0] q
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             tc;

   mod_n_tc #(
      .WIDTH (WIDTH)
   ) u_tc (
      .cnt   (q_q),
      .n_mod (n_conut),
      .tc    (tc)
   );

   // Any count at or beyond the terminal value wraps, so a shrinking modulus never overshoots.
   always_comb begin
      q_d = q_q + ONE;
      if (tc) begin
         q_d = WIDTH'(CNT_ZERO);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_q <= WIDTH'(CNT_ZERO);
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : bin_256_cnt_free_run

// File: tb/tb_bin_256_cnt_free_run.sv
// Self-checking bench for bin_256_cnt_free_run: directed scenarios plus a random
// phase, checked against an arithmetic model of the modulo-N counting rule.
module tb_bin_256_cnt_free_run;

   logic       clk;
   logic       reset;
   logic [7:0] n_conut;
   logic [7:0] q;

   int n_checks;
   int n_fail;
   int model_q;

   bin_256_cnt_free_run #(
      .WIDTH (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .n_conut (n_conut),
      .q       (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int eff_n(input logic [7:0] n);
      return (n == 8'd0) ? 256 : int'(n);
   endfunction

   task automatic chk(input string tag, input int expected);
      logic [7:0] obs;
      obs = q;
      n_checks++;
      assert (obs === expected[7:0])
      else begin
         n_fail++;
         $error("FAIL %s: q=%0d expected %0d (t=%0t)", tag, obs, expected, $time);
      end
   endtask

   // One clock: model advances with the modulus present at the edge, then q is checked.
   task automatic step(input string tag);
      int n;
      n = eff_n(n_conut);
      @(posedge clk);
      #1;
      if (reset) begin
         model_q = (model_q + 1 >= n) ? 0 : model_q + 1;
      end else begin
         model_q = 0;
      end
      chk(tag, model_q);
   endtask

   // Reset pulse spanning a few edges, released just after an edge.
   task automatic do_reset(input int cycles);
      #2;
      reset   = 1'b0;
      model_q = 0;
      #1;
      chk("rst_async", 0);
      for (int i = 0; i < cycles; i++) begin
         step("rst_hold");
      end
      reset = 1'b1;
      #1;
      chk("rst_release", 0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      model_q  = 0;
      reset    = 1'b0;
      n_conut  = 8'd163;

      // Modulus 163, reset held 3 clocks: 0 during reset, then period 163.
      #1;
      chk("por_zero", 0);
      for (int i = 0; i < 3; i++) step("por_hold");
      reset = 1'b1;
      #1;
      chk("por_release", 0);
      for (int k = 1; k <= 330; k++) begin
         step("n163");
         if (k == 162) chk("n163_top", 162);
         if (k == 163) chk("n163_wrap", 0);
         if (k == 326) chk("n163_period2", 0);
      end

      // Modulus 0 runs the full 256 range.
      n_conut = 8'd0;
      do_reset(2);
      for (int k = 1; k <= 300; k++) begin
         step("n0");
         if (k == 255) chk("n0_255", 255);
         if (k == 256) chk("n0_wrap", 0);
         if (k == 300) chk("n0_300", 44);
      end

      // Modulus 1 holds zero.
      n_conut = 8'd1;
      do_reset(1);
      for (int k = 1; k <= 20; k++) step("n1_hold");

      // Modulus shrink from 200 to 100 while q = 150.
      n_conut = 8'd200;
      do_reset(1);
      for (int k = 1; k <= 150; k++) step("n200");
      chk("n200_at150", 150);
      n_conut = 8'd100;
      step("shrink_zero");
      chk("shrink_is0", 0);
      for (int k = 1; k <= 100; k++) begin
         step("n100");
         if (k == 99) chk("n100_top", 99);
         if (k == 100) chk("n100_wrap", 0);
      end

      // Asynchronous reset mid-cycle at q = 77.
      n_conut = 8'd163;
      do_reset(1);
      for (int k = 1; k <= 77; k++) step("pre77");
      chk("at77", 77);
      #2;
      reset   = 1'b0;
      model_q = 0;
      #1;
      chk("abort_immediate", 0);
      step("abort_hold");
      reset = 1'b1;
      step("abort_first");
      chk("abort_first_is1", 1);

      // Modulus 2 alternates.
      n_conut = 8'd2;
      do_reset(1);
      for (int k = 1; k <= 10; k++) begin
         step("n2");
         chk("n2_alt", k % 2);
      end

      // Random modulus changes and occasional reset pulses.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 19) == 0) begin
            if ($urandom_range(0, 1) == 0) n_conut = 8'($urandom_range(0, 255));
            else n_conut = 8'($urandom_range(0, 6));
         end
         if ($urandom_range(0, 199) == 0) begin
            do_reset($urandom_range(0, 2));
         end else begin
            step("random");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule : tb_bin_256_cnt_free_run
